// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store bus bridge: access sizes, FSM states and
// the default read-response timeout.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_NONE = 2'b00,
    SZ_WORD = 2'b01,
    SZ_HALF = 2'b10,
    SZ_BYTE = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RSP,
    ST_DONE
  } state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the LSU: store byte enables and lane-replicated write
// data, plus lane extraction and sign/zero extension of load data.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  size_e       req_size,
  input  logic [1:0]  req_off,
  input  logic [31:0] store_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  size_e       ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] rdata,
  output logic [31:0] ld_result
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    case (req_size)
      SZ_BYTE: begin
        be    = 4'b0001 << req_off;
        wdata = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        be    = req_off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_off)
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];

    ld_result = rdata;
    case (ld_size)
      SZ_BYTE: ld_result = {{24{ld_byte[7] & ~ld_unsigned}}, ld_byte};
      SZ_HALF: ld_result = {{16{ld_half[15] & ~ld_unsigned}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Load/store unit: turns decoded size/direction controls into one handshaked
// data-bus transaction, stalling the core until it completes.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses fail without a bus request.
module lsu_bus_bridge
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_write,
  input  logic [1:0]  mem_read,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        access_err,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_e      state_q, state_d;
  size_e       size_q, size_d;
  logic        we_q, we_d;
  logic [1:0]  off_q, off_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] load_data_q, load_data_d;
  logic        err_q, err_d;

  logic        req_we;
  size_e       req_size;
  logic        req_pending;
  logic        misalign;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] ld_ext;
  logic [7:0]  cnt_inc;

  // Stores win when the decoder flags both directions.
  assign req_we      = (mem_write != SZ_NONE);
  assign req_size    = req_we ? size_e'(mem_write) : size_e'(mem_read);
  assign req_pending = (req_size != SZ_NONE);
  assign cnt_inc     = cnt_q + 8'd1;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_size == SZ_HALF) && addr[0]) ||
                    ((req_size == SZ_WORD) && (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  lsu_lane_align u_lane_align (
    .req_size    (req_size),
    .req_off     (addr[1:0]),
    .store_data  (store_data),
    .be          (lane_be),
    .wdata       (lane_wdata),
    .ld_size     (size_q),
    .ld_off      (off_q),
    .ld_unsigned (uns_q),
    .rdata       (bus_rdata),
    .ld_result   (ld_ext)
  );

  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch below can infer a latch.
    state_d     = state_q;
    size_d      = size_q;
    we_d        = we_q;
    off_d       = off_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    load_data_d = load_data_q;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_pending) begin
          size_d  = req_size;
          we_d    = req_we;
          off_d   = addr[1:0];
          uns_d   = load_unsigned;
          addr_d  = word_align(addr);
          be_d    = lane_be;
          wdata_d = lane_wdata;
          if (misalign) begin
            state_d     = ST_DONE;
            err_d       = 1'b1;
            load_data_d = '0;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (bus_ready) begin
          state_d = we_q ? ST_DONE : ST_RSP;
          cnt_d   = '0;
        end
      end
      ST_RSP: begin
        // A response is only sampled here, never in the acceptance cycle.
        if (bus_rvalid) begin
          load_data_d = ld_ext;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_CNT) begin
            load_data_d = '0;
            err_d       = 1'b1;
            state_d     = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      size_q      <= SZ_NONE;
      we_q        <= 1'b0;
      off_q       <= '0;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      load_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      we_q        <= we_d;
      off_q       <= off_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
      err_q       <= err_d;
    end
  end

  // The IDLE term is combinational so the core freezes in the cycle it presents the access.
  assign stall = ~reset & (((state_q == ST_IDLE) & req_pending) |
                           (state_q == ST_REQ) | (state_q == ST_RSP));

  assign bus_valid  = (state_q == ST_REQ);
  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_be     = be_q;
  assign bus_wdata  = wdata_q;
  assign load_data  = load_data_q;
  assign access_err = err_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Self-checking bench for lsu_bus_bridge (default build, TIMEOUT=4): directed
// cases plus randomized back-to-back accesses against a behavioural model.
module tb_lsu_bus_bridge;

  localparam int TO    = 4;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_write, mem_read;
  logic        load_unsigned;
  logic [31:0] addr, store_data;
  logic        stall;
  logic [31:0] load_data;
  logic        access_err;
  logic        bus_valid, bus_ready, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_load = '0;

  lsu_bus_bridge #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_write     (mem_write),
    .mem_read      (mem_read),
    .load_unsigned (load_unsigned),
    .addr          (addr),
    .store_data    (store_data),
    .stall         (stall),
    .load_data     (load_data),
    .access_err    (access_err),
    .bus_valid     (bus_valid),
    .bus_ready     (bus_ready),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_be        (bus_be),
    .bus_wdata     (bus_wdata),
    .bus_rvalid    (bus_rvalid),
    .bus_rdata     (bus_rdata)
  );

  always #5 clk = ~clk;

  // Reference model: sizes 1=word, 2=half, 3=byte.
  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    int k;
    k = int'(a % 4);
    if (sz == 2'd3) return 4'(1 << k);
    if (sz == 2'd2) return (k >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] sd);
    if (sz == 2'd3) return (sd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd2) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [31:0] a,
                                         input logic uns, input logic [31:0] rd);
    logic [31:0] v;
    if (sz == 2'd3) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2'd2) begin
      v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic run_access(input string name, input logic is_wr, input logic [1:0] sz,
                            input logic uns, input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] rd, input int rdy_dly, input int rv_dly,
                            input logic junk_early, input logic gap);
    int          exp_stall, rsp_cycles, vcnt, rwait, stall_cnt;
    logic        exp_err, accepted, accept_now, done;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_addr, exp_ld;

    exp_be     = m_be(sz, a);
    exp_wd     = m_wdata(sz, sd);
    exp_addr   = a & 32'hFFFF_FFFC;
    rsp_cycles = (rv_dly < TO) ? rv_dly + 1 : TO;
    exp_err    = !is_wr && (rv_dly >= TO);
    exp_stall  = is_wr ? 2 + rdy_dly : 2 + rdy_dly + rsp_cycles;
    exp_ld     = is_wr ? model_load : (exp_err ? 32'd0 : m_load(sz, a, uns, rd));
    model_load = exp_ld;

    @(negedge clk);
    mem_write     = is_wr ? sz : 2'b00;
    mem_read      = is_wr ? 2'b00 : sz;
    load_unsigned = uns;
    addr          = a;
    store_data    = sd;
    vcnt = 0; rwait = 0; stall_cnt = 0;
    accepted = 1'b0; done = 1'b0;

    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (cyc != 0) @(negedge clk);
      bus_rvalid = 1'b0;
      bus_rdata  = 32'hDEAD_BEEF;
      bus_ready  = 1'b0;
      accept_now = 1'b0;
      if (accepted) begin
        if (rwait == rv_dly) begin
          bus_rvalid = 1'b1;
          bus_rdata  = rd;
        end
        rwait++;
      end
      if (bus_valid) begin
        bus_ready  = (vcnt >= rdy_dly);
        accept_now = bus_ready;
        vcnt++;
        checks++;
        if (bus_addr !== exp_addr || bus_be !== exp_be || bus_we !== is_wr ||
            (is_wr && bus_wdata !== exp_wd)) begin
          errors++;
          $display("FAIL %s req: addr=%h be=%b we=%b wdata=%h want addr=%h be=%b we=%b wdata=%h",
                   name, bus_addr, bus_be, bus_we, bus_wdata, exp_addr, exp_be, is_wr, exp_wd);
        end
        if (accept_now && junk_early && !is_wr) begin
          bus_rvalid = 1'b1;
          bus_rdata  = ~rd;
        end
      end
      accepted = accepted | accept_now;
      #1;
      if (stall) begin
        stall_cnt++;
      end else begin
        done = 1'b1;
        checks++;
        if (stall_cnt !== exp_stall || load_data !== exp_ld || access_err !== exp_err ||
            vcnt !== rdy_dly + 1) begin
          errors++;
          $display("FAIL %s done: stall_cyc=%0d ld=%h err=%b valid_cyc=%0d want %0d %h %b %0d",
                   name, stall_cnt, load_data, access_err, vcnt, exp_stall, exp_ld, exp_err,
                   rdy_dly + 1);
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no completion seen within 200 cycles", name);
    end

    if (gap) begin
      @(negedge clk);
      mem_write  = 2'b00;
      mem_read   = 2'b00;
      bus_rvalid = 1'b0;
      bus_ready  = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b0 || access_err !== 1'b0 || load_data !== exp_ld) begin
        errors++;
        $display("FAIL %s after: stall=%b err=%b ld=%h want 0 0 %h",
                 name, stall, access_err, load_data, exp_ld);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    mem_write = 2'b00; mem_read = 2'b00; load_unsigned = 1'b0;
    addr = '0; store_data = '0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (stall !== 1'b0 || bus_valid !== 1'b0 || bus_we !== 1'b0 || access_err !== 1'b0 ||
        bus_addr !== '0 || bus_be !== '0 || bus_wdata !== '0 || load_data !== '0) begin
      errors++;
      $display("FAIL reset_state: stall=%b valid=%b we=%b err=%b addr=%h be=%b wd=%h ld=%h want all 0",
               stall, bus_valid, bus_we, access_err, bus_addr, bus_be, bus_wdata, load_data);
    end
    reset = 1'b0;
    model_load = '0;
  endtask

  task automatic test_directed;
    run_access("sb_1003", 1'b1, 2'd3, 1'b0, 32'h1003, 32'h0000_00A5, 32'h0, 0, 0, 1'b0, 1'b1);
    run_access("lb_2001", 1'b0, 2'd3, 1'b0, 32'h2001, 32'h0, 32'h0000_8000, 0, 0, 1'b0, 1'b1);
    run_access("lbu_2001", 1'b0, 2'd3, 1'b1, 32'h2001, 32'h0, 32'h0000_8000, 0, 0, 1'b0, 1'b1);
    run_access("lh_2002_wait", 1'b0, 2'd2, 1'b0, 32'h2002, 32'h0, 32'h7FFF_1234, 3, 1, 1'b1, 1'b1);
    run_access("lw_timeout", 1'b0, 2'd1, 1'b0, 32'h4000, 32'h0, 32'h1111_2222, 0, NEVER, 1'b0, 1'b1);
    run_access("sw_3002", 1'b1, 2'd1, 1'b0, 32'h3002, 32'hCAFE_F00D, 32'h0, 1, 0, 1'b0, 1'b1);
    run_access("lh_odd", 1'b0, 2'd2, 1'b0, 32'h5003, 32'h0, 32'h8001_0203, 0, 2, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid;
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    mem_read = 2'b01;
    addr     = 32'h6000;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (bus_valid) begin
        bus_ready = 1'b1;
        seen = 1'b1;
      end
    end
    @(negedge clk);
    bus_ready = 1'b0;
    #1;
    checks++;
    if (!seen || stall !== 1'b1 || bus_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_rsp: seen=%b stall=%b valid=%b want 1 1 0", seen, stall, bus_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || bus_valid !== 1'b0 || access_err !== 1'b0 ||
        bus_addr !== '0 || load_data !== '0) begin
      errors++;
      $display("FAIL rst_mid_now: stall=%b valid=%b err=%b addr=%h ld=%h want 0",
               stall, bus_valid, access_err, bus_addr, load_data);
    end
    @(negedge clk);
    mem_read = 2'b00;
    reset    = 1'b0;
    model_load = '0;
    @(negedge clk);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h1234_5678;
    #1;
    checks++;
    if (stall !== 1'b0 || bus_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_late_rvalid: stall=%b valid=%b want 0 0", stall, bus_valid);
    end
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    checks++;
    if (load_data !== '0 || access_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_ignored: ld=%h err=%b want 0 0", load_data, access_err);
    end
    run_access("lw_after_rst", 1'b0, 2'd1, 1'b0, 32'h7008, 32'h0, 32'hA5A5_0F0F, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back;
    logic [1:0]  sz;
    logic        wr, uns;
    logic [31:0] a, sd, rd;
    int          rdy, rv, pick;
    for (int n = 0; n < 40; n++) begin
      sz   = 2'($urandom_range(1, 3));
      wr   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      a    = $urandom;
      sd   = $urandom;
      rd   = $urandom;
      rdy  = $urandom_range(0, 3);
      pick = $urandom_range(0, 3);
      rv   = (pick == 3) ? NEVER : pick;
      run_access("b2b", wr, sz, uns, a, sd, rd, rdy, rv, 1'($urandom_range(0, 1)), n == 39);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
